// File: rtl/controle_portao_if.sv
// Signal bundle between the gate controller and its surroundings:
// limit switches, obstacle sensor and command button in, motor drive and
// status out.
interface controle_portao_if;
    logic       fa;      // limit switch, gate fully open
    logic       ff;      // limit switch, gate fully closed
    logic       s;       // obstacle sensor
    logic       c;       // command button (level)
    logic       abrir;   // motor drive, open direction
    logic       fechar;  // motor drive, close direction
    logic [2:0] estado;  // current state encoding, debug only
    logic       falha;   // fault indicator

    // Controller side: reads the field inputs, drives the motor and status.
    modport slave (
        input  fa,
        input  ff,
        input  s,
        input  c,
        output abrir,
        output fechar,
        output estado,
        output falha
    );

    // Environment side: drives the field inputs, observes the controller.
    modport master (
        output fa,
        output ff,
        output s,
        output c,
        input  abrir,
        input  fechar,
        input  estado,
        input  falha
    );
endinterface

// File: rtl/controle_portao.sv
// Gate-entry motor controller. Registered state machine with command edge
// detection, obstacle reversal, auto-close timer, motor-run timeout and a
// dead-time before every direction reversal. Outputs are Moore-decoded from
// the state register, so abrir and fechar can never be high together.
module controle_portao #(
    parameter int unsigned T_AUTO  = 8,   // cycles held OPEN before auto-close
    parameter int unsigned T_MAX   = 32,  // max motor run cycles before fault
    parameter int unsigned T_PAUSA = 2    // idle cycles before any reversal
) (
    input  logic               clk,
    input  logic               rst_n,
    controle_portao_if.slave   bus
);

    typedef enum logic [2:0] {
        FECHADO  = 3'd0,
        ABRINDO  = 3'd1,
        ABERTO   = 3'd2,
        FECHANDO = 3'd3,
        PAUSA    = 3'd4,
        FALHA    = 3'd5
    } estado_t;

    // A timeout of T cycles is reached when cnt == T-1 at the clock edge.
    localparam logic [15:0] LIM_AUTO  = 16'(T_AUTO  - 1);
    localparam logic [15:0] LIM_MAX   = 16'(T_MAX   - 1);
    localparam logic [15:0] LIM_PAUSA = 16'(T_PAUSA - 1);

    estado_t     state;
    estado_t     state_nx;
    logic        c_q;
    logic        c_rise;
    logic [15:0] cnt;
    logic [15:0] cnt_nx;
    logic        dir;      // 1 = open after the pause, 0 = close
    logic        dir_nx;
    logic        t_auto;
    logic        t_max;
    logic        t_pausa;

    // A button held through reset release reads as a fresh press because
    // c_q comes out of reset at 0.
    assign c_rise  = bus.c & ~c_q;

    assign t_auto  = (cnt == LIM_AUTO);
    assign t_max   = (cnt == LIM_MAX);
    assign t_pausa = (cnt == LIM_PAUSA);

    // State, counter, direction and button history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FECHADO;
            cnt   <= '0;
            dir   <= 1'b0;
            c_q   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            dir   <= dir_nx;
            c_q   <= bus.c;
        end
    end

    // Next-state and reversal-direction decision.
    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        // Both limit switches active is physically impossible: a sensor has
        // failed, so stop everything regardless of what the gate was doing.
        if (state != FALHA && bus.fa && bus.ff) begin
            state_nx = FALHA;
        end else begin
            unique case (state)
                FECHADO: begin
                    if (c_rise) begin
                        state_nx = ABRINDO;
                    end else if (!bus.ff) begin
                        // Gate drifted off (or came out of reset) not fully
                        // closed: drive it home.
                        state_nx = FECHANDO;
                    end
                end
                ABRINDO: begin
                    // Obstacle sensor deliberately ignored while opening.
                    if (bus.fa) begin
                        state_nx = ABERTO;
                    end else if (t_max) begin
                        state_nx = FALHA;
                    end else if (c_rise) begin
                        state_nx = PAUSA;
                        dir_nx   = 1'b0;
                    end
                end
                ABERTO: begin
                    if (c_rise) begin
                        state_nx = FECHANDO;
                    end else if (!bus.s && t_auto) begin
                        state_nx = FECHANDO;
                    end
                end
                FECHANDO: begin
                    // Obstacle wins over the closed switch: never trust ff
                    // while something is in the gateway.
                    if (bus.s) begin
                        state_nx = PAUSA;
                        dir_nx   = 1'b1;
                    end else if (bus.ff) begin
                        state_nx = FECHADO;
                    end else if (t_max) begin
                        state_nx = FALHA;
                    end else if (c_rise) begin
                        state_nx = PAUSA;
                        dir_nx   = 1'b1;
                    end
                end
                PAUSA: begin
                    if (t_pausa) begin
                        state_nx = dir ? ABRINDO : FECHANDO;
                    end
                end
                FALHA: begin
                    // Latched until rst_n; no input can clear it.
                    state_nx = FALHA;
                end
                default: begin
                    state_nx = FECHADO;
                end
            endcase
        end
    end

    // Cycle counter: restarts on every state change, runs in the timed
    // states, and is held at zero while an obstacle keeps the gate open.
    always_comb begin
        cnt_nx = cnt;
        if (state_nx != state) begin
            cnt_nx = '0;
        end else begin
            unique case (state)
                ABERTO:                   cnt_nx = bus.s ? 16'd0 : cnt + 16'd1;
                ABRINDO, FECHANDO, PAUSA: cnt_nx = cnt + 16'd1;
                default:                  cnt_nx = cnt;
            endcase
        end
    end

    assign bus.abrir  = (state == ABRINDO);
    assign bus.fechar = (state == FECHANDO);
    assign bus.falha  = (state == FALHA);
    assign bus.estado = state;

endmodule

// File: tb/tb_controle_portao.sv
// Directed bench for controle_portao. Each step queues the expected state
// before the clock edge and checks the outputs 1 ns after it; motor and
// fault outputs are expected from the state encoding.
module tb_controle_portao;

    logic clk;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    string      tagq[$];
    logic [2:0] stq[$];

    controle_portao_if bus();

    controle_portao #(
        .T_AUTO  (8),
        .T_MAX   (32),
        .T_PAUSA (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare_front();
        string      tag;
        logic [2:0] st;
        logic [5:0] exp_v;
        logic [5:0] got_v;
        tag   = tagq.pop_front();
        st    = stq.pop_front();
        exp_v = {st, (st == 3'd1), (st == 3'd3), (st == 3'd5)};
        got_v = {bus.estado, bus.abrir, bus.fechar, bus.falha};
        vectors++;
        assert (got_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s: estado/abrir/fechar/falha got %0d/%b/%b/%b expected %0d/%b/%b/%b",
                   tag, got_v[5:3], got_v[2], got_v[1], got_v[0],
                   exp_v[5:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] st);
        tagq.push_back(tag);
        stq.push_back(st);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    task automatic now_chk(input string tag, input logic [2:0] st);
        tagq.push_back(tag);
        stq.push_back(st);
        #1;
        compare_front();
    endtask

    task automatic steps(input string tag, input int n, input logic [2:0] st);
        for (int i = 0; i < n; i++) step(tag, st);
    endtask

    initial begin
        rst_n  = 1'b0;
        bus.fa = 1'b0;
        bus.ff = 1'b1;
        bus.s  = 1'b0;
        bus.c  = 1'b0;

        // Reset state, then idle closed
        #3 now_chk("rst_async", 3'd0);
        step("rst_hold", 3'd0);
        rst_n = 1'b1;
        step("idle_closed", 3'd0);

        // Normal cycle
        bus.c = 1'b1;
        step("c_open", 3'd1);
        bus.c  = 1'b0;
        bus.ff = 1'b0;
        steps("opening", 9, 3'd1);
        bus.fa = 1'b1;
        step("fa_open", 3'd2);
        steps("open_wait", 7, 3'd2);
        step("auto_close", 3'd3);
        bus.fa = 1'b0;
        steps("closing", 3, 3'd3);
        bus.ff = 1'b1;
        step("ff_closed", 3'd0);
        step("stay_closed", 3'd0);

        // Homing, then obstacle reversal
        bus.ff = 1'b0;
        step("homing", 3'd3);
        step("closing2", 3'd3);
        bus.s = 1'b1;
        step("obstacle", 3'd4);
        bus.s = 1'b0;
        step("pause1", 3'd4);
        step("reopen", 3'd1);
        bus.s = 1'b1;
        step("s_ignored_open", 3'd1);
        bus.s = 1'b0;

        // Hold-open
        bus.fa = 1'b1;
        step("open2", 3'd2);
        bus.s = 1'b1;
        steps("hold", 20, 3'd2);
        bus.s = 1'b0;
        steps("hold_release", 7, 3'd2);
        step("auto_close2", 3'd3);
        bus.fa = 1'b0;

        // Command reversal while closing, then while opening
        bus.c = 1'b1;
        step("c_rev_close", 3'd4);
        bus.c = 1'b0;
        step("pause_c1", 3'd4);
        step("rev_to_open", 3'd1);
        step("opening3", 3'd1);
        bus.c = 1'b1;
        step("c_rev_open", 3'd4);
        bus.c = 1'b0;
        step("pause_c2", 3'd4);
        step("rev_to_close", 3'd3);

        // Obstacle beats closed switch
        bus.s  = 1'b1;
        bus.ff = 1'b1;
        step("s_beats_ff", 3'd4);
        bus.s  = 1'b0;
        bus.ff = 1'b0;
        step("pause_s", 3'd4);
        step("rev_after_s", 3'd1);

        // Sensor fault, inputs ignored, reset clears
        bus.fa = 1'b1;
        step("open3", 3'd2);
        bus.ff = 1'b1;
        step("fa_ff_fault", 3'd5);
        bus.fa = 1'b0;
        bus.ff = 1'b0;
        bus.c  = 1'b1;
        step("fault_c1", 3'd5);
        bus.c = 1'b0;
        step("fault_c0", 3'd5);
        bus.c = 1'b1;
        step("fault_c2", 3'd5);
        bus.c = 1'b0;
        steps("fault_hold", 3, 3'd5);
        #2 rst_n = 1'b0;
        now_chk("fault_rst", 3'd0);
        bus.ff = 1'b1;
        step("rst_hold2", 3'd0);
        rst_n = 1'b1;
        step("closed_after_rst", 3'd0);

        // Motor timeout
        bus.c = 1'b1;
        step("c_open_to", 3'd1);
        bus.c  = 1'b0;
        bus.ff = 1'b0;
        steps("run_to", 31, 3'd1);
        step("motor_timeout", 3'd5);
        bus.c = 1'b1;
        step("to_c1", 3'd5);
        bus.c = 1'b0;
        step("to_c0", 3'd5);
        bus.c = 1'b1;
        step("to_c2", 3'd5);
        bus.c  = 1'b0;
        bus.fa = 1'b1;
        step("to_fa_ignored", 3'd5);
        bus.fa = 1'b0;
        #2 rst_n = 1'b0;
        now_chk("to_rst", 3'd0);
        step("rst_hold3", 3'd0);
        rst_n = 1'b1;
        step("homing_after_rst", 3'd3);
        step("closing4", 3'd3);

        // Async reset mid-run
        #2 rst_n = 1'b0;
        now_chk("midrun_rst", 3'd0);
        step("midrun_hold", 3'd0);
        rst_n = 1'b1;
        step("reenter_close", 3'd3);

        // Button held high across reset release counts as a press
        #2 rst_n = 1'b0;
        bus.ff = 1'b1;
        bus.c  = 1'b1;
        now_chk("rst_c_high", 3'd0);
        step("rst_hold4", 3'd0);
        rst_n = 1'b1;
        step("c_high_release", 3'd1);
        step("c_level_held", 3'd1);
        bus.c = 1'b0;
        bus.ff = 1'b0;
        step("opening_end", 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/controle_portao.md
Name: controle_portao

Overview:
- Sequential controller for the gate-entry motor drive (abrir/fechar).
- Replaces purely combinational decoding with a registered state machine. It adds edge-detected command handling, obstacle reversal, an auto-close timer, a motor-run timeout and a reversal dead-time.
- Sits between the limit switches, obstacle sensor and command button and the motor driver. The two motor outputs are never active together.

Parameters:
- T_AUTO, 8: cycles the gate stays OPEN (sensor clear) before auto-closing.
- T_MAX, 32: maximum cycles of motor run (OPENING or CLOSING) before fault.
- T_PAUSA, 2: cycles both motor outputs are held low before any direction reversal.
- All parameters are 1..65535.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- fa  input  1  limit switch, gate fully open (1 = reached).
- ff  input  1  limit switch, gate fully closed (1 = reached).
- s  input  1  obstacle sensor (1 = obstacle in gateway).
- c  input  1  command button, level; acted on at its rising edge.
- abrir  output  1  motor drive, open direction.
- fechar  output  1  motor drive, close direction.
- estado  output  3  current state encoding, for debug.
- falha  output  1  fault indicator.

Behaviour:
- Command edge detect:
  - c_q is a register of c; reset value 0.
  - c_rise = c & ~c_q.
  - If c is high when reset is released, that counts as a rise on the first clock.
- Counter cnt:
  - 16 bits, reset value 0.
  - Cleared on every state change.
  - Increments each cycle in ABRINDO, ABERTO, FECHANDO and PAUSA.
  - "Timeout T" means cnt == T-1 at the clock edge, i.e. the state has lasted T cycles.
- Direction register dir (1 = open next, 0 = close next): set on entry to PAUSA; reset value 0.
- States (estado encoding):
  - FECHADO = 0, ABRINDO = 1, ABERTO = 2, FECHANDO = 3, PAUSA = 4, FALHA = 5.
  - Reset state is FECHADO.
- Outputs are Moore, decoded from the state register only:
  - abrir = (state == ABRINDO).
  - fechar = (state == FECHANDO).
  - falha = (state == FALHA).
  - Reset values: abrir = 0, fechar = 0, falha = 0, estado = 0. These apply immediately on rst_n low, without a clock edge.
- Global rule, highest priority: fa & ff both 1 in any state other than FALHA -> FALHA next edge.
- FECHADO:
  - c_rise -> ABRINDO.
  - Else if ff == 0 -> FECHANDO (homing/drift correction, including after reset).
- ABRINDO, priority order:
  - fa -> ABERTO.
  - Timeout T_MAX -> FALHA.
  - c_rise -> PAUSA with dir = 0.
  - s is ignored while opening.
- ABERTO:
  - c_rise -> FECHANDO.
  - s == 1 clears cnt every cycle (hold open).
  - Timeout T_AUTO with s == 0 -> FECHANDO.
- FECHANDO, priority order:
  - s -> PAUSA with dir = 1 (obstacle beats ff).
  - ff -> FECHADO.
  - Timeout T_MAX -> FALHA.
  - c_rise -> PAUSA with dir = 1.
- PAUSA:
  - Both drives are 0; c_rise and s are ignored.
  - Timeout T_PAUSA -> ABRINDO if dir == 1, else FECHANDO.
- FALHA:
  - Both drives are 0; falha = 1.
  - All inputs are ignored; the only exit is rst_n low.
- Invariant: abrir & fechar == 0 in every cycle.
- Latency:
  - One clock from the qualifying input at the edge to the output change.
  - Every reversal inserts exactly T_PAUSA idle cycles.
- Reset mid-operation: rst_n low drops abrir and fechar asynchronously and returns the block to FECHADO.

Test Plan:
Parameters for all scenarios: T_AUTO = 8, T_MAX = 32, T_PAUSA = 2.
- Normal cycle:
  - Stimulus: reset with ff=1, fa=0; pulse c; raise fa after 10 cycles, keep s=0; then raise ff while closing.
  - Response: c pulse gives abrir=1, estado=1 at the next edge. fa gives estado=2, abrir=0. Exactly 8 cycles later fechar=1, estado=3. ff gives fechar=0, estado=0.
- Obstacle reversal:
  - Stimulus: in FECHANDO, raise s=1 for 1 cycle.
  - Response: next edge fechar=0, estado=4. Both drives stay 0 for 2 cycles, then abrir=1, estado=1.
- Hold-open:
  - Stimulus: in ABERTO, hold s=1 for 20 cycles, then drop s.
  - Response: fechar stays 0 throughout the hold. fechar=1 exactly 8 cycles after s falls.
- Motor timeout:
  - Stimulus: enter ABRINDO with fa held 0; after the fault, pulse c repeatedly; then pulse rst_n low.
  - Response: after 32 cycles abrir=0, falha=1, estado=5. The c pulses have no effect. rst_n low gives falha=0, estado=0.
- Sensor fault and command reversal:
  - Stimulus (a): fa=ff=1 while in ABERTO.
  - Response (a): falha=1 at the next edge.
  - Stimulus (b): separately, a c pulse during ABRINDO.
  - Response (b): estado=4 for 2 cycles, then fechar=1.
- Async reset mid-run:
  - Stimulus: in FECHANDO, drive rst_n low between clock edges.
  - Response: fechar=0 and estado=0 before the next rising edge. After release with ff=0 and c=0, FECHANDO is re-entered at the second edge.
